// File: rtl/btn_debounce.sv
// btn_debounce: per-button two-flop synchroniser, bounce filter with a
// stability counter, debounced level and one-cycle press/release pulses.
// Optional toggle register enabled by defining BTN_DEBOUNCE_TOGGLE_EN;
// without it btn_toggle is tied to zero.
module btn_debounce #(
  parameter int unsigned NBTN      = 7,
  parameter int unsigned DB_CYCLES = 250000,
  parameter int unsigned CNT_W     = 18
) (
  input  logic            clk_25mhz,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_state,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NBTN-1:0] btn_toggle
);

  // Terminal count: a level differing on this count is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [NBTN-1:0]  sync1;
  logic [NBTN-1:0]  sync2;
  logic [CNT_W-1:0] cnt [NBTN];

  // Two-flop synchroniser bringing the raw pins into the clock domain.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Stability counters; any return to the current level discards progress.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      btn_state   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < int'(NBTN); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < int'(NBTN); i++) begin
        if (sync2[i] == btn_state[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i]         <= '0;
          btn_state[i]   <= sync2[i];
          btn_press[i]   <= sync2[i];
          btn_release[i] <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef BTN_DEBOUNCE_TOGGLE_EN
  // Push-on/push-off register, flipping the cycle after each press pulse.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      btn_toggle <= '0;
    end else begin
      btn_toggle <= btn_toggle ^ btn_press;
    end
  end
`else
  // Feature disabled: constant zero, no flops.
  assign btn_toggle = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce with NBTN=7, DB_CYCLES=4.
// Outputs are sampled 1 time unit after each rising edge.
module tb_btn_debounce;

  localparam int unsigned NBTN = 7;
  localparam int unsigned DBC  = 4;
  localparam int unsigned LAT  = DBC + 2;

  logic            clk_25mhz = 1'b0;
  logic            rst;
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_state;
  logic [NBTN-1:0] btn_press;
  logic [NBTN-1:0] btn_release;
  logic [NBTN-1:0] btn_toggle;

  int n_cmp = 0;
  int n_err = 0;

  logic [NBTN-1:0] st_exp  = '0;
  logic [NBTN-1:0] tog_exp = '0;
  logic [NBTN-1:0] prev_p  = '0;

  btn_debounce #(.NBTN(NBTN), .DB_CYCLES(DBC), .CNT_W(3)) dut (
    .clk_25mhz  (clk_25mhz),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_toggle (btn_toggle)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic chk(input string tag, input logic [NBTN-1:0] obs, input logic [NBTN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"},   btn_state,   st_exp);
    chk({tag, ".press"},   btn_press,   prev_p);
    chk({tag, ".release"}, btn_release, '0);
    chk({tag, ".toggle"},  btn_toggle,  tog_exp);
  endtask

  // One edge with expected press/release pulses p and r on that edge.
  task automatic tick_exp(input string tag, input logic [NBTN-1:0] p, input logic [NBTN-1:0] r);
    @(posedge clk_25mhz); #1;
`ifdef BTN_DEBOUNCE_TOGGLE_EN
    tog_exp = tog_exp ^ prev_p;
`endif
    prev_p = p;
    st_exp = (st_exp | p) & ~r;
    chk({tag, ".state"},   btn_state,   st_exp);
    chk({tag, ".press"},   btn_press,   p);
    chk({tag, ".release"}, btn_release, r);
    chk({tag, ".toggle"},  btn_toggle,  tog_exp);
  endtask

  // n quiet edges, then on edge n the given pulses.
  task automatic run_check(input string tag, input int n, input logic [NBTN-1:0] p, input logic [NBTN-1:0] r);
    for (int i = 1; i < n; i++) tick_exp(tag, '0, '0);
    tick_exp(tag, p, r);
  endtask

  // Assert reset (checked immediately and on each held edge), then release.
  task automatic do_reset(input string tag, input int n);
    rst = 1'b1; #1;
    st_exp = '0; tog_exp = '0; prev_p = '0;
    chk_all(tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_25mhz); #1;
      chk_all(tag);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = 7'h7F;
    #1;

    // Reset period with all buttons held: everything stays zero.
    do_reset("rst_hold", 3);
    // Held buttons qualify as fresh presses after full latency.
    run_check("rst_rel", LAT, 7'h7F, 7'h00);
    tick_exp("rst_rel_after", '0, '0);
    btn_raw = 7'h00;
    run_check("rel_all", LAT, 7'h00, 7'h7F);
    tick_exp("rel_all_after", '0, '0);

    // Clean press on bit 2.
    btn_raw = 7'h04;
    run_check("clean", LAT, 7'h04, 7'h00);
    tick_exp("clean_after", '0, '0);
    btn_raw = 7'h00;
    run_check("clean_rel", LAT, 7'h00, 7'h04);

    // Bounce: 3 high, 1 low, then held high.
    btn_raw = 7'h04;
    for (int i = 0; i < 3; i++) tick_exp("bounce_hi", '0, '0);
    btn_raw = 7'h00;
    tick_exp("bounce_lo", '0, '0);
    btn_raw = 7'h04;
    run_check("bounce", LAT, 7'h04, 7'h00);
    tick_exp("bounce_after", '0, '0);

    // Bits 0 and 5 pressed, then fall while bit 3 rises.
    btn_raw = 7'h25;
    run_check("pre_sim", LAT, 7'h21, 7'h00);
    btn_raw = 7'h0C;
    run_check("simul", LAT, 7'h08, 7'h21);
    tick_exp("simul_after", '0, '0);

    // Reset two counts into qualifying bit 1; full latency after release.
    btn_raw = 7'h0E;
    for (int i = 0; i < 4; i++) tick_exp("midcnt", '0, '0);
    do_reset("midcnt_rst", 2);
    run_check("midcnt_rel", LAT, 7'h0E, 7'h00);
    tick_exp("midcnt_after", '0, '0);

    // Toggle: three presses on bit 4 from a clean reset.
    btn_raw = 7'h00;
    do_reset("tog_rst", 1);
    for (int k = 0; k < 3; k++) begin
      btn_raw = 7'h10;
      run_check("tog_press", LAT, 7'h10, 7'h00);
      tick_exp("tog_flip", '0, '0);
`ifdef BTN_DEBOUNCE_TOGGLE_EN
      chk("tog_bit4", {6'b0, btn_toggle[4]}, (k % 2 == 0) ? 7'h01 : 7'h00);
`else
      chk("tog_off", btn_toggle, 7'h00);
`endif
      btn_raw = 7'h00;
      run_check("tog_rel", LAT, 7'h00, 7'h10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
